uart_line_arbiter: RTL and testbench

- Shares the single `string_writer` / UART transmit path between NUM_REQ independent line producers (key handlers, status reporters, SD-card file dumper).
- Each requester presents an 80-character line and raises a request. The arbiter grants round-robin, latches the winning line and pulses `send` into the writer.
- It holds off further grants until the writer has finished transmitting, then applies a configurable inter-line gap.

---
 rtl/uart_line_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_line_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_arbiter.sv
// Round-robin arbiter sharing one string_writer/UART transmit path among NUM_REQ line producers.
// Latches the winning line, pulses send, waits out the transfer and then an inter-line gap.
module uart_line_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LINE_W       = 640,
    parameter int unsigned BUSY_TIMEOUT = 1023,
    parameter int unsigned GAP_CYCLES   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*LINE_W-1:0]    req_line,
    output logic [NUM_REQ-1:0]           ack,
    output logic [LINE_W-1:0]            wr_line,
    output logic                         wr_send,
    input  logic                         wr_busy,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic                         active,
    output logic                         err_timeout
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned TMO_W = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);
    localparam int unsigned GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        WAIT_DONE,
        GAP
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [LINE_W-1:0]    wr_line_q, wr_line_d;
    logic                 wr_send_q, wr_send_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic                 active_q, active_d;
    logic                 err_timeout_q, err_timeout_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;

    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     cand;

    // Rotating-priority search starting just after the last winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = IDX_W'((32'(last_grant_q) + 32'(k) + 32'd1) % NUM_REQ);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ack_d          = '0;
        wr_send_d      = 1'b0;
        err_timeout_d  = 1'b0;
        wr_line_d      = wr_line_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        tmo_cnt_d      = tmo_cnt_q;
        gap_cnt_d      = gap_cnt_q;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    wr_line_d        = req_line[32'(grant_idx) * LINE_W +: LINE_W];
                    ack_d[grant_idx] = 1'b1;
                    owner_d          = grant_idx;
                    last_grant_d     = grant_idx;
                    state_d          = LAUNCH;
                end
            end
            LAUNCH: begin
                wr_send_d = 1'b1;
                tmo_cnt_d = '0;
                state_d   = WAIT_START;
            end
            WAIT_START: begin
                if (wr_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_cnt_q == TMO_W'(BUSY_TIMEOUT)) begin
                    // Writer never accepted the line; drop it and move on.
                    err_timeout_d = 1'b1;
                    gap_cnt_d     = '0;
                    state_d       = GAP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!wr_busy) begin
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (32'(gap_cnt_q) + 32'd1 >= GAP_CYCLES) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ack_q         <= '0;
            wr_line_q     <= '0;
            wr_send_q     <= 1'b0;
            owner_q       <= '0;
            last_grant_q  <= IDX_W'(NUM_REQ - 1);
            active_q      <= 1'b0;
            err_timeout_q <= 1'b0;
            tmo_cnt_q     <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            wr_line_q     <= wr_line_d;
            wr_send_q     <= wr_send_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            active_q      <= active_d;
            err_timeout_q <= err_timeout_d;
            tmo_cnt_q     <= tmo_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign ack         = ack_q;
    assign wr_line     = wr_line_q;
    assign wr_send     = wr_send_q;
    assign owner       = owner_q;
    assign active      = active_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_line_arbiter.sv
// Directed self-checking bench for uart_line_arbiter: grant order, handshake timing, gap, timeout, reset.
module tb_uart_line_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned LW   = 640;
    localparam int unsigned BT   = 1023;
    localparam int unsigned GAP  = 16;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*LW-1:0] req_line;
    logic [NREQ-1:0]    ack;
    logic [LW-1:0]      wr_line;
    logic               wr_send;
    logic               wr_busy;
    logic [1:0]         owner;
    logic               active;
    logic               err_timeout;

    logic [LW-1:0]      lines [NREQ];
    int                 total;
    int                 bad;

    uart_line_arbiter #(
        .NUM_REQ     (NREQ),
        .LINE_W      (LW),
        .BUSY_TIMEOUT(BT),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_line   (req_line),
        .ack        (ack),
        .wr_line    (wr_line),
        .wr_send    (wr_send),
        .wr_busy    (wr_busy),
        .owner      (owner),
        .active     (active),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Serve one line for requester g: checks the grant, the send pulse and the busy+gap window.
    task automatic serve_line(input int g, input int busy_len, input bit drop, input bit pulse3);
        int n;
        int extra;
        logic [NREQ-1:0] exp_ack;
        exp_ack = NREQ'(1) << g;
        n = 0;
        extra = 0;
        step();
        while (ack === '0 && n < 64) begin
            step();
            n++;
        end
        total++;
        if (ack !== exp_ack) begin
            bad++;
            $display("FAIL grant_ack%0d: got %b want %b", g, ack, exp_ack);
        end
        total++;
        if (owner !== 2'(g)) begin
            bad++;
            $display("FAIL grant_owner%0d: got %0d want %0d", g, owner, g);
        end
        total++;
        if (wr_line !== lines[g]) begin
            bad++;
            $display("FAIL grant_line%0d: got %h want %h", g, wr_line, lines[g]);
        end
        total++;
        if (active !== 1'b1 || wr_send !== 1'b0) begin
            bad++;
            $display("FAIL grant_flags%0d: got active=%b send=%b want active=1 send=0", g, active, wr_send);
        end
        if (drop) req[g] = 1'b0;
        if (pulse3) req[3] = 1'b1;
        step();
        total++;
        if (ack !== '0 || wr_send !== 1'b1) begin
            bad++;
            $display("FAIL send_pulse%0d: got ack=%b send=%b want ack=0000 send=1", g, ack, wr_send);
        end
        wr_busy = 1'b1;
        for (int i = 0; i < busy_len; i++) begin
            step();
            if (pulse3 && i == busy_len / 2) req[3] = 1'b0;
            if (wr_send !== 1'b0 || ack !== '0 || active !== 1'b1) extra++;
        end
        wr_busy = 1'b0;
        n = 0;
        do begin
            step();
            n++;
            if (wr_send !== 1'b0 || ack !== '0) extra++;
        end while (active === 1'b1 && n < 200);
        total++;
        if (n !== int'(GAP) + 1) begin
            bad++;
            $display("FAIL release_cycles%0d: got %0d want %0d", g, n, GAP + 1);
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL in_flight_glitches%0d: got %0d want 0", g, extra);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req     = '0;
        wr_busy = 1'b0;
        step();
        step();
        total++;
        if (ack !== '0 || wr_send !== 1'b0 || active !== 1'b0 || err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got ack=%b send=%b act=%b err=%b want all 0", ack, wr_send, active, err_timeout);
        end
        total++;
        if (wr_line !== '0 || owner !== 2'd0) begin
            bad++;
            $display("FAIL reset_regs: got owner=%0d line=%h want 0", owner, wr_line);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        wr_busy = 1'b1;
        step();
        step();
        total++;
        if (active !== 1'b0 || ack !== '0 || wr_send !== 1'b0) begin
            bad++;
            $display("FAIL idle_ignores_busy: got act=%b ack=%b send=%b want 0", active, ack, wr_send);
        end
        wr_busy = 1'b0;
    endtask

    task automatic test_single();
        req = 4'b0001;
        serve_line(0, 200, 1'b1, 1'b0);
    endtask

    task automatic test_simultaneous();
        req = 4'b0110;
        serve_line(1, 20, 1'b1, 1'b0);
        serve_line(2, 20, 1'b1, 1'b0);
    endtask

    task automatic test_withdrawn();
        req = 4'b0001;
        serve_line(0, 30, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step();
        total++;
        if (ack !== '0 || wr_send !== 1'b0 || active !== 1'b0) begin
            bad++;
            $display("FAIL withdrawn_req: got ack=%b send=%b act=%b want 0", ack, wr_send, active);
        end
    endtask

    task automatic test_timeout();
        int n;
        req = 4'b0110;
        step();
        total++;
        if (ack !== 4'b0010) begin
            bad++;
            $display("FAIL tmo_grant: got %b want 0010", ack);
        end
        req[1] = 1'b0;
        step();
        step();
        total++;
        if (wr_send !== 1'b0) begin
            bad++;
            $display("FAIL tmo_send_drop: got %b want 0", wr_send);
        end
        n = 0;
        while (err_timeout !== 1'b1 && n < int'(BT) + 50) begin
            step();
            n++;
        end
        total++;
        if (n !== int'(BT)) begin
            bad++;
            $display("FAIL tmo_latency: got %0d want %0d", n, BT);
        end
        step();
        total++;
        if (err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL tmo_pulse_width: got %b want 0", err_timeout);
        end
        n = 0;
        while (ack === '0 && n < 100) begin
            step();
            n++;
        end
        total++;
        if (n !== int'(GAP) || ack !== 4'b0100 || owner !== 2'd2) begin
            bad++;
            $display("FAIL tmo_next_grant: got wait=%0d ack=%b owner=%0d want wait=%0d ack=0100 owner=2", n, ack, owner, GAP);
        end
        req = '0;
        do_reset();
    endtask

    task automatic test_fairness();
        req = 4'b1111;
        for (int ln = 0; ln < 8; ln++) begin
            serve_line(ln % 4, 5, ln == 7, 1'b0);
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        req = 4'b0010;
        step();
        total++;
        if (ack !== 4'b0010) begin
            bad++;
            $display("FAIL mid_grant: got %b want 0010", ack);
        end
        req = '0;
        step();
        wr_busy = 1'b1;
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (ack !== '0 || wr_send !== 1'b0 || active !== 1'b0 || err_timeout !== 1'b0 ||
            owner !== 2'd0 || wr_line !== '0) begin
            bad++;
            $display("FAIL async_reset: got ack=%b send=%b act=%b err=%b owner=%0d want all 0",
                     ack, wr_send, active, err_timeout, owner);
        end
        wr_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        req = 4'b1000;
        serve_line(3, 10, 1'b1, 1'b0);
        req = 4'b1001;
        serve_line(0, 10, 1'b1, 1'b0);
        serve_line(3, 10, 1'b1, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        lines[0] = {"Hello Rosie!\n\r", 528'd0};
        for (int i = 1; i < int'(NREQ); i++) begin
            lines[i] = {"Line from req", 8'(8'h30 + i), 528'hA5};
        end
        req_line = {lines[3], lines[2], lines[1], lines[0]};
        test_reset();
        test_single();
        test_simultaneous();
        test_withdrawn();
        test_timeout();
        test_fairness();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
